// File: rtl/load_store_unit.sv
// load_store_unit: RV32I data-memory initiator with sub-word load extraction and read-modify-write stores
// Ports: clk/reset_n (sync active-low); req_* one request at a time, accepted in IDLE;
//   resp_* one-cycle completion pulse with load data and error flags;
//   mem_* word-aligned access to a combinational-read, synchronous-write memory.
// Optional: define LSU_BOUNDS_CHECK_EN to fault requests with addr[31:2] >= WORDS.
module load_store_unit #(
   parameter int WORDS = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_misaligned,
   output logic        resp_illegal,
   output logic        resp_fault,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_write_enable,
   input  logic [31:0] mem_data
);
   localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3;
   logic [1:0] state, next_state;
   logic wr, misaligned, illegal, fault;
   logic [2:0] f3;
   logic [31:0] addr, wdata, word;
   logic accept, req_illegal, req_misaligned, req_fault;
   logic [4:0] bsh, hsh;
   logic [7:0] byte_v;
   logic [15:0] half_v;
   logic [31:0] load_v, merged;
   assign accept = req_valid && state == IDLE;
   assign req_illegal = req_write ? req_funct3 >= 3'd3 : (req_funct3 == 3'd3 || req_funct3 >= 3'd6);
   assign req_misaligned = !req_illegal && ((req_funct3[1:0] == 2'd1 && req_addr[0]) ||
                                            (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0));
`ifdef LSU_BOUNDS_CHECK_EN
   assign req_fault = !req_illegal && !req_misaligned && ({2'b00, req_addr[31:2]} >= 32'(WORDS));
`else
   assign req_fault = 1'b0 & (WORDS > 0);
`endif
   always_ff @(posedge clk)
      if (!reset_n) state <= IDLE;
      else state <= next_state;
   always_ff @(posedge clk)
      if (!reset_n) begin
         {wr, f3, addr, wdata, word, misaligned, illegal, fault} <= '0;
      end else begin
         if (accept) begin
            wr         <= req_write;
            f3         <= req_funct3;
            addr       <= req_addr;
            wdata      <= req_wdata;
            misaligned <= req_misaligned;
            illegal    <= req_illegal;
            fault      <= req_fault;
         end
         if (state == READ) word <= mem_data;
      end
   // SW skips READ because it overwrites the whole word; SB/SH need the old word first.
   always_comb begin
      next_state = state == IDLE  ? (!req_valid ? IDLE :
                                     (req_illegal || req_misaligned || req_fault) ? RESP :
                                     (req_write && req_funct3 == 3'd2) ? WRITE : READ) :
                   state == READ  ? (wr ? WRITE : RESP) :
                   state == WRITE ? RESP : IDLE;
   end
   always_comb begin
      bsh              = {addr[1:0], 3'b000};
      hsh              = {addr[1], 4'b0000};
      byte_v           = 8'(word >> bsh);
      half_v           = 16'(word >> hsh);
      load_v           = f3 == 3'd0 ? {{24{byte_v[7]}}, byte_v} :
                         f3 == 3'd1 ? {{16{half_v[15]}}, half_v} :
                         f3 == 3'd4 ? {24'b0, byte_v} :
                         f3 == 3'd5 ? {16'b0, half_v} : word;
      merged           = f3 == 3'd0 ? (word & ~(32'hFF << bsh)) | ({24'b0, wdata[7:0]} << bsh) :
                         f3 == 3'd1 ? (word & ~(32'hFFFF << hsh)) | ({16'b0, wdata[15:0]} << hsh) : wdata;
      req_ready        = state == IDLE;
      resp_valid       = state == RESP;
      resp_misaligned  = resp_valid && misaligned;
      resp_illegal     = resp_valid && illegal;
      resp_fault       = resp_valid && fault;
      resp_rdata       = (resp_valid && !wr && !misaligned && !illegal && !fault) ? load_v : 32'b0;
      mem_address      = {addr[31:2], 2'b00};
      // Gated by reset_n so a reset landing on the WRITE cycle cannot corrupt memory.
      mem_write_enable = state == WRITE && reset_n;
      mem_write_data   = state == WRITE ? merged : 32'b0;
   end
endmodule
